// File: rtl/conv7_stream_ctrl.sv
// conv7_stream_ctrl
// Raster-scan sequencer feeding a 7x7 convolution engine. Buffers the
// previous six lines, presents one 56-bit column per accepted pixel, tracks
// which columns carry a complete window through the engine latency, and
// forwards results with valid/ready plus the window-centre coordinates.
// The end of each frame is drained with PIPE_LAT zero columns.
// Optional statistics ports are built when CONV7_CTRL_STATS_EN is defined.

module conv7_stream_ctrl #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int PIPE_LAT = 8,
    parameter int K        = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic [7:0]  in_pixel,
    output logic        conv_valid,
    output logic [55:0] conv_col,
    input  logic [31:0] conv_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic        frame_done
`ifdef CONV7_CTRL_STATS_EN
    ,
    output logic [31:0] stat_out_cnt,
    output logic [31:0] stat_stall_cnt,
    output logic        stat_abort
`endif
);

    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int FW   = $clog2(PIPE_LAT + 1);
    localparam int HALF = K / 2;
    localparam int LBW  = 8 * (K - 1);

    localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
    localparam logic [XW-1:0] X_EDGE      = XW'(K - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_FILL_LAST = YW'(K - 2);
    localparam logic [FW-1:0] F_LAST      = FW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XW-1:0]   x;
    logic [XW-1:0]   x_next;
    logic [YW-1:0]   y;
    logic [YW-1:0]   y_next;
    logic [FW-1:0]   flush_cnt;
    logic [FW-1:0]   flush_next;
    logic            done_next;

    logic            head_valid;
    logic            adv;
    logic            accept;
    logic            sof_hit;
    logic            abort;
    logic            col_tag;
    logic [XW-1:0]   col_x;
    logic [YW-1:0]   col_y;
    logic [XW-1:0]   mem_addr;
    logic [LBW-1:0]  line_rd;
    logic            mem_we;

    // One wide word per column holds rows y-6 (top byte) .. y-1 (bottom byte)
    logic [LBW-1:0]  line_mem [WIDTH];

    logic [PIPE_LAT-1:0] tag_pipe;
    logic [XW-1:0]       x_pipe [PIPE_LAT];
    logic [YW-1:0]       y_pipe [PIPE_LAT];
    logic                taken;

    // Handshake, engine enable, line-buffer read and the column tag
    always_comb begin
        head_valid = tag_pipe[PIPE_LAT-1] & ~taken;
        out_valid  = ~reset & head_valid;
        adv        = ~out_valid | out_ready;
        in_ready   = ~reset & (state != FLUSH) & adv;
        accept     = in_valid & in_ready;
        sof_hit    = accept & in_sof;
        abort      = sof_hit & ((state == FILL) | (state == RUN));

        if (state == FLUSH) begin
            conv_valid = ~reset & adv;
        end else begin
            conv_valid = accept & ((state != IDLE) | in_sof);
        end

        mem_addr = sof_hit ? '0 : x;
        line_rd  = line_mem[mem_addr];
        mem_we   = conv_valid & (state != FLUSH);

        if (~reset & (state != FLUSH)) begin
            conv_col = {line_rd, in_pixel};
        end else begin
            conv_col = '0;
        end

        col_tag = (state == RUN) & ~sof_hit & (x >= X_EDGE);
        col_x   = (state == FLUSH) ? '0 : mem_addr;
        col_y   = ((state == FLUSH) | sof_hit) ? '0 : y;
    end

    // Result side: data straight from the engine, coordinates moved to the window centre
    always_comb begin
        out_data = conv_result;
        if (out_valid) begin
            out_x = 16'(x_pipe[PIPE_LAT-1]) - 16'(HALF);
            out_y = 16'(y_pipe[PIPE_LAT-1]) - 16'(HALF);
        end else begin
            out_x = '0;
            out_y = '0;
        end
    end

    // Next-state and raster counter logic
    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        flush_next = flush_cnt;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (sof_hit) begin
                    state_next = FILL;
                    x_next     = XW'(1);
                    y_next     = '0;
                end
            end
            FILL, RUN: begin
                if (sof_hit) begin
                    state_next = FILL;
                    x_next     = XW'(1);
                    y_next     = '0;
                end else if (accept) begin
                    if (x == X_LAST) begin
                        x_next = '0;
                        y_next = y + YW'(1);
                        if ((state == FILL) && (y == Y_FILL_LAST)) begin
                            state_next = RUN;
                        end else if ((state == RUN) && (y == Y_LAST)) begin
                            state_next = FLUSH;
                            y_next     = '0;
                            flush_next = '0;
                        end
                    end else begin
                        x_next = x + XW'(1);
                    end
                end
            end
            FLUSH: begin
                if (conv_valid) begin
                    if (flush_cnt == F_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        x_next     = '0;
                        y_next     = '0;
                        flush_next = '0;
                    end else begin
                        flush_next = flush_cnt + FW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and the end-of-frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            flush_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            x          <= x_next;
            y          <= y_next;
            flush_cnt  <= flush_next;
            frame_done <= done_next;
        end
    end

    // Line buffer: read-before-write at the current column, rows shift up by one
    always_ff @(posedge clk) begin
        if (mem_we) begin
            line_mem[mem_addr] <= {line_rd[LBW-9:0], in_pixel};
        end
    end

    // Tag pipe follows the engine; an abort wipes every older tag in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_pipe <= '0;
            taken    <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
            end
        end else if (conv_valid) begin
            if (abort) begin
                tag_pipe <= {{(PIPE_LAT-1){1'b0}}, col_tag};
            end else begin
                tag_pipe <= {tag_pipe[PIPE_LAT-2:0], col_tag};
            end
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                x_pipe[i] <= x_pipe[i-1];
                y_pipe[i] <= y_pipe[i-1];
            end
            x_pipe[0] <= col_x;
            y_pipe[0] <= col_y;
            taken     <= 1'b0;
        end else if (out_valid & out_ready) begin
            taken <= 1'b1;
        end
    end

`ifdef CONV7_CTRL_STATS_EN
    // Delivered results, stall cycles and a sticky mid-frame restart flag
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_out_cnt   <= '0;
            stat_stall_cnt <= '0;
            stat_abort     <= 1'b0;
        end else begin
            if (out_valid & out_ready & (stat_out_cnt != '1)) begin
                stat_out_cnt <= stat_out_cnt + 32'd1;
            end
            if (out_valid & ~out_ready & (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
            if (abort) begin
                stat_abort <= 1'b1;
            end
        end
    end
`endif

endmodule
